// File: rtl/regs_write_arbiter.sv
// regs_write_arbiter
// Shares the single register-file write port between the execute (p0) and
// load/store (p1) writeback paths. One requester is granted per cycle. The
// winning write is registered towards the register file, and the write still
// in flight is forwarded onto both read ports so decode never sees stale data.
module regs_write_arbiter #(
    parameter int unsigned FIXED_PRIO = 0  // 0: round-robin on conflict, 1: p0 always wins
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        p0_valid_i,
    output logic        p0_ready_o,
    input  logic [4:0]  p0_addr_i,
    input  logic [31:0] p0_data_i,

    input  logic        p1_valid_i,
    output logic        p1_ready_o,
    input  logic [4:0]  p1_addr_i,
    input  logic [31:0] p1_data_i,

    output logic        write_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,

    input  logic [4:0]  raddr1_i,
    input  logic [31:0] regs_rdata1_i,
    output logic [31:0] rdata1_o,

    input  logic [4:0]  raddr2_i,
    input  logic [31:0] regs_rdata2_i,
    output logic [31:0] rdata2_o
);

    localparam logic PORT_P0 = 1'b0;
    localparam logic PORT_P1 = 1'b1;

    // Arbitration state: index of the port granted most recently.
    logic        last_grant_q, last_grant_d;

    // Registered write towards the register file.
    logic        write_q, write_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    // Per-cycle arbitration results.
    logic        grant_p0;
    logic        grant_p1;
    logic        grant_any;
    logic [4:0]  grant_addr;
    logic [31:0] grant_data;

    // Pick the winner: a lone requester always wins; on conflict either p0
    // (fixed priority) or whichever port did not win last time.
    always_comb begin
        grant_p0 = 1'b0;
        grant_p1 = 1'b0;
        if (p0_valid_i && p1_valid_i) begin
            if ((FIXED_PRIO != 0) || (last_grant_q == PORT_P1)) begin
                grant_p0 = 1'b1;
            end else begin
                grant_p1 = 1'b1;
            end
        end else begin
            grant_p0 = p0_valid_i;
            grant_p1 = p1_valid_i;
        end
    end

    assign grant_any = grant_p0 | grant_p1;

    // Mux the winning request's payload; defaults to p0 when nothing is granted
    // (the value is ignored in that case).
    always_comb begin
        grant_addr = p0_addr_i;
        grant_data = p0_data_i;
        if (grant_p1) begin
            grant_addr = p1_addr_i;
            grant_data = p1_data_i;
        end
    end

    // A request held while reset is asserted must not complete a handshake,
    // so ready is gated by reset directly rather than by the flops alone.
    assign p0_ready_o = grant_p0 & rst_ni;
    assign p1_ready_o = grant_p1 & rst_ni;

    // Next-state: record the winner, capture the write; x0 targets complete the
    // handshake but never raise the write enable.
    always_comb begin
        last_grant_d = last_grant_q;
        write_d      = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        if (grant_any) begin
            last_grant_d = grant_p1 ? PORT_P1 : PORT_P0;
            write_d      = (grant_addr != 5'd0);
            waddr_d      = grant_addr;
            wdata_d      = grant_data;
        end
    end

    // State registers; last_grant resets to p1 so p0 wins the first conflict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= PORT_P1;
            write_q      <= 1'b0;
            waddr_q      <= 5'd0;
            wdata_q      <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign write_o = write_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

    // Forward the in-flight write to each read port independently; x0 is never
    // forwarded since it always reads as the register file supplies it.
    always_comb begin
        rdata1_o = regs_rdata1_i;
        rdata2_o = regs_rdata2_i;
        if (write_q && (raddr1_i != 5'd0) && (waddr_q == raddr1_i)) begin
            rdata1_o = wdata_q;
        end
        if (write_q && (raddr2_i != 5'd0) && (waddr_q == raddr2_i)) begin
            rdata2_o = wdata_q;
        end
    end

endmodule

// File: tb/tb_regs_write_arbiter.sv
// Bench for regs_write_arbiter: round-robin (dut 0) and fixed-priority (dut 1)
// instances share stimulus; each is checked against its own reference model,
// and a model register file supplies the read data.
module tb_regs_write_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p0_valid, p1_valid;
    logic [4:0]  p0_addr, p1_addr, raddr1, raddr2;
    logic [31:0] p0_data, p1_data, regs_rdata1, regs_rdata2;

    logic        p0_ready [2];
    logic        p1_ready [2];
    logic        write_en [2];
    logic [4:0]  waddr    [2];
    logic [31:0] wdata    [2];
    logic [31:0] rdata1   [2];
    logic [31:0] rdata2   [2];

    regs_write_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_valid_i(p0_valid), .p0_ready_o(p0_ready[0]), .p0_addr_i(p0_addr), .p0_data_i(p0_data),
        .p1_valid_i(p1_valid), .p1_ready_o(p1_ready[0]), .p1_addr_i(p1_addr), .p1_data_i(p1_data),
        .write_o(write_en[0]), .waddr_o(waddr[0]), .wdata_o(wdata[0]),
        .raddr1_i(raddr1), .regs_rdata1_i(regs_rdata1), .rdata1_o(rdata1[0]),
        .raddr2_i(raddr2), .regs_rdata2_i(regs_rdata2), .rdata2_o(rdata2[0])
    );

    regs_write_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_valid_i(p0_valid), .p0_ready_o(p0_ready[1]), .p0_addr_i(p0_addr), .p0_data_i(p0_data),
        .p1_valid_i(p1_valid), .p1_ready_o(p1_ready[1]), .p1_addr_i(p1_addr), .p1_data_i(p1_data),
        .write_o(write_en[1]), .waddr_o(waddr[1]), .wdata_o(wdata[1]),
        .raddr1_i(raddr1), .regs_rdata1_i(regs_rdata1), .rdata1_o(rdata1[1]),
        .raddr2_i(raddr2), .regs_rdata2_i(regs_rdata2), .rdata2_o(rdata2[1])
    );

    // Reference model state, one set per instance; rf follows the round-robin dut.
    int          lg [2];
    bit          wr [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [31:0] rf [32];
    bit          eg0 [2];
    bit          eg1 [2];
    bit          ovr_en;
    logic [31:0] ovr_val;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] fwd_exp(input int m, input logic [4:0] ra, input logic [31:0] fed);
        if (wr[m] && ra != 5'd0 && wa[m] == ra) return wd[m];
        return fed;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            lg[m] = 1; wr[m] = 0; wa[m] = '0; wd[m] = '0;
        end
    endtask

    // First half of a cycle: inputs are already applied; check combinational outputs.
    task automatic half_a();
        regs_rdata1 = ovr_en ? ovr_val : rf[raddr1];
        regs_rdata2 = ovr_en ? ovr_val : rf[raddr2];
        #1;
        for (int m = 0; m < 2; m++) begin
            if (p0_valid && p1_valid) begin
                eg0[m] = (m == 1) || (lg[m] == 1);
                eg1[m] = !eg0[m];
            end else begin
                eg0[m] = p0_valid;
                eg1[m] = p1_valid;
            end
            chk($sformatf("dut%0d.p0_ready", m), p0_ready[m], eg0[m]);
            chk($sformatf("dut%0d.p1_ready", m), p1_ready[m], eg1[m]);
            chk($sformatf("dut%0d.rdata1", m), rdata1[m], fwd_exp(m, raddr1, regs_rdata1));
            chk($sformatf("dut%0d.rdata2", m), rdata2[m], fwd_exp(m, raddr2, regs_rdata2));
        end
    endtask

    // Second half: clock edge, advance the models, check registered outputs.
    task automatic half_b();
        @(posedge clk);
        if (wr[0]) rf[wa[0]] = wd[0];
        for (int m = 0; m < 2; m++) begin
            if (eg0[m] || eg1[m]) begin
                wa[m] = eg0[m] ? p0_addr : p1_addr;
                wd[m] = eg0[m] ? p0_data : p1_data;
                wr[m] = (wa[m] != 5'd0);
                lg[m] = eg1[m] ? 1 : 0;
            end else begin
                wr[m] = 0;
            end
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("dut%0d.write_o", m), write_en[m], wr[m]);
            chk($sformatf("dut%0d.waddr_o", m), waddr[m], wa[m]);
            chk($sformatf("dut%0d.wdata_o", m), wdata[m], wd[m]);
        end
        @(negedge clk);
    endtask

    task automatic step();
        half_a();
        half_b();
    endtask

    // Reset applied at a negedge while whatever request is present stays present.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst.dut%0d.p0_ready", m), p0_ready[m], 1'b0);
            chk($sformatf("rst.dut%0d.p1_ready", m), p1_ready[m], 1'b0);
            chk($sformatf("rst.dut%0d.write_o", m), write_en[m], 1'b0);
            chk($sformatf("rst.dut%0d.waddr_o", m), waddr[m], 5'd0);
            chk($sformatf("rst.dut%0d.wdata_o", m), wdata[m], 32'd0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle();
        p0_valid = 0; p1_valid = 0;
        p0_addr = '0; p1_addr = '0; p0_data = '0; p1_data = '0;
    endtask

    bit          pend0, pend1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        ovr_en = 0; ovr_val = '0;
        raddr1 = '0; raddr2 = '0;
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Single p0 write: granted at once, visible one cycle later.
        p0_valid = 1; p0_addr = 5'd5; p0_data = 32'hDEADBEEF;
        half_a();
        chk("single.p0_ready", p0_ready[0], 1'b1);
        half_b();
        chk("single.write_o", write_en[0], 1'b1);
        chk("single.waddr_o", waddr[0], 5'd5);
        chk("single.wdata_o", wdata[0], 32'hDEADBEEF);

        // Forwarding: write reg 7, then read reg 7 on port 1 and reg 8 on port 2.
        p0_addr = 5'd7; p0_data = 32'hA5A5A5A5;
        step();
        idle();
        raddr1 = 5'd7; raddr2 = 5'd8;
        half_a();
        chk("fwd.rdata1", rdata1[0], 32'hA5A5A5A5);
        chk("fwd.rdata2", rdata2[0], 32'd0);
        half_b();

        // x0 write: handshake completes, no write; x0 read is never forwarded.
        p1_valid = 1; p1_addr = 5'd0; p1_data = 32'h12345678;
        half_a();
        chk("x0.p1_ready", p1_ready[0], 1'b1);
        half_b();
        chk("x0.write_o", write_en[0], 1'b0);
        idle();
        raddr1 = 5'd0; ovr_en = 1; ovr_val = 32'hCAFEF00D;
        half_a();
        chk("x0.rdata1", rdata1[0], 32'hCAFEF00D);
        half_b();
        ovr_en = 0;

        // Mid-handshake reset after p1 last won: first conflict afterwards goes to p0.
        p1_valid = 1; p1_addr = 5'd9; p1_data = 32'h99;
        step();
        p0_valid = 1; p0_addr = 5'd4; p0_data = 32'h44;
        do_reset();

        // Round-robin vs fixed priority conflict over four cycles.
        p0_valid = 1; p0_addr = 5'd1; p0_data = 32'h101;
        p1_valid = 1; p1_addr = 5'd2; p1_data = 32'h202;
        for (int i = 0; i < 4; i++) begin
            half_a();
            chk("rr.p0_ready", p0_ready[0], (i % 2) == 0);
            chk("rr.p1_ready", p1_ready[0], (i % 2) == 1);
            chk("fp.p0_ready", p0_ready[1], 1'b1);
            chk("fp.p1_ready", p1_ready[1], 1'b0);
            half_b();
            chk("rr.waddr_o", waddr[0], ((i % 2) == 0) ? 5'd1 : 5'd2);
            chk("fp.waddr_o", waddr[1], 5'd1);
        end
        idle();
        step();

        // Same-address conflict: p0 wins first, loser's data ends in the register.
        do_reset();
        p0_valid = 1; p0_addr = 5'd3; p0_data = 32'h11;
        p1_valid = 1; p1_addr = 5'd3; p1_data = 32'h22;
        step();
        chk("same.wdata_first", wdata[0], 32'h11);
        p0_valid = 0;
        step();
        chk("same.wdata_second", wdata[0], 32'h22);
        idle();
        raddr1 = 5'd3;
        half_a();
        chk("same.fwd_reg3", rdata1[0], 32'h22);
        half_b();
        half_a();
        chk("same.rf_reg3", rdata1[0], 32'h22);
        half_b();

        // Randomized traffic following the round-robin dut's handshake.
        pend0 = 0; pend1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend0 && ($urandom_range(0, 1) == 1)) begin
                pend0 = 1; a0 = 5'($urandom_range(0, 7)); d0 = $urandom;
            end
            if (!pend1 && ($urandom_range(0, 1) == 1)) begin
                pend1 = 1; a1 = 5'($urandom_range(0, 7)); d1 = $urandom;
            end
            p0_valid = pend0; p0_addr = a0; p0_data = d0;
            p1_valid = pend1; p1_addr = a1; p1_data = d1;
            raddr1 = 5'($urandom_range(0, 7));
            raddr2 = 5'($urandom_range(0, 7));
            if (c == 200) begin
                do_reset();
            end else begin
                step();
                if (eg0[0]) pend0 = 0;
                if (eg1[0]) pend1 = 0;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
